// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port among four
// requesters (ALU writeback, load unit, I/O input, debug port).
// After reset it zero-fills all 16 registers, then grants one requester per
// cycle in round-robin order.
// Optional feature: define RF_WR_PROT_EN to make register 0 read-only during
// RUN. A blocked write is still acked and pulses prot_err for one cycle.
module rf_write_arbiter #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [3:0]        req_addr0,
    input  logic [3:0]        req_addr1,
    input  logic [3:0]        req_addr2,
    input  logic [3:0]        req_addr3,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    input  logic [DATA_W-1:0] req_data3,
    output logic [3:0]        ack,
    output logic              wr_en,
    output logic [3:0]        wr_sel,
    output logic [DATA_W-1:0] wr_data,
    output logic              init_done,
    output logic              prot_err
);

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned LAST_RF = 15;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                wr_en_q, wr_en_d;
    logic [SEL_W-1:0]    wr_sel_q, wr_sel_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                init_done_q, init_done_d;
`ifdef RF_WR_PROT_EN
    logic                prot_err_q, prot_err_d;
`endif

    logic                found;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W-1:0]    probe_idx;
    logic [N_REQ-1:0]    grant;
    logic [SEL_W-1:0]    win_addr;
    logic [DATA_W-1:0]   win_data;

    // Round-robin search starting at ptr; only active in RUN.
    always_comb begin
        found     = 1'b0;
        win_idx   = '0;
        probe_idx = '0;
        grant     = '0;
        if (state_q == ST_RUN) begin
            for (int k = 0; k < int'(N_REQ); k++) begin
                probe_idx = ptr_q + PTR_W'(k);
                if (!found && req[probe_idx]) begin
                    found            = 1'b1;
                    win_idx          = probe_idx;
                    grant[probe_idx] = 1'b1;
                end
            end
        end
    end

    // Route the winning requester's address and data.
    always_comb begin
        win_addr = req_addr0;
        win_data = req_data0;
        case (win_idx)
            2'd0: begin win_addr = req_addr0; win_data = req_data0; end
            2'd1: begin win_addr = req_addr1; win_data = req_data1; end
            2'd2: begin win_addr = req_addr2; win_data = req_data2; end
            default: begin win_addr = req_addr3; win_data = req_data3; end
        endcase
    end

    // Next-state and registered-output logic for the INIT/RUN sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        wr_en_d     = 1'b0;
        wr_sel_d    = wr_sel_q;
        wr_data_d   = wr_data_q;
        init_done_d = init_done_q;
`ifdef RF_WR_PROT_EN
        prot_err_d  = 1'b0;
`endif
        case (state_q)
            ST_INIT: begin
                wr_en_d   = 1'b1;
                wr_sel_d  = cnt_q;
                wr_data_d = '0;
                cnt_d     = cnt_q + SEL_W'(1);
                if (cnt_q == SEL_W'(LAST_RF)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                if (found) begin
                    ptr_d = win_idx + PTR_W'(1);
`ifdef RF_WR_PROT_EN
                    // Register 0 is hard-wired zero: ack the write but drop it.
                    if (win_addr == SEL_W'(0)) begin
                        prot_err_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_sel_d  = win_addr;
                        wr_data_d = win_data;
                    end
`else
                    wr_en_d   = 1'b1;
                    wr_sel_d  = win_addr;
                    wr_data_d = win_data;
`endif
                end
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ptr_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_sel_q    <= '0;
            wr_data_q   <= '0;
            init_done_q <= 1'b0;
`ifdef RF_WR_PROT_EN
            prot_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            wr_en_q     <= wr_en_d;
            wr_sel_q    <= wr_sel_d;
            wr_data_q   <= wr_data_d;
            init_done_q <= init_done_d;
`ifdef RF_WR_PROT_EN
            prot_err_q  <= prot_err_d;
`endif
        end
    end

    assign ack       = grant;
    assign wr_en     = wr_en_q;
    assign wr_sel    = wr_sel_q;
    assign wr_data   = wr_data_q;
    assign init_done = init_done_q;
`ifdef RF_WR_PROT_EN
    assign prot_err  = prot_err_q;
`else
    assign prot_err  = 1'b0;
`endif

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port of the single-cycle processor among four write requesters: ALU writeback, load unit, I/O input, and debug port. After reset it sequences a zero-fill of all 16 registers. It then grants one requester per cycle, round-robin. It drives the 4-bit select that feeds the 4-to-16 write-enable decoder, plus the write-enable and write-data lines of the register file.

## Interface
- DATA_W, 8, width of register data
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  4  per-requester write request; bit i = requester i
- req_addr0..req_addr3  in  4 each  target register of requester i
- req_data0..req_data3  in  DATA_W each  write data of requester i
- ack  out  4  one-hot combinational grant; ack[i]=1 means requester i's write is captured at this edge
- wr_en  out  1  registered register-file write enable
- wr_sel  out  4  registered register index to the 4-to-16 decoder
- wr_data  out  DATA_W  registered write data
- init_done  out  1  registered; 1 once the zero-fill has completed
- prot_err  out  1  registered one-cycle pulse, present only with RF_WR_PROT_EN (see Configuration)

## Operation
- One clock; reset is synchronous and active-high.
- States:
  - INIT: zero-fill sequence; entered on reset.
  - RUN: arbitration.
- Reset effects: state=INIT, fill counter cnt=0, rr pointer ptr=0. Outputs wr_en=0, wr_sel=0, wr_data=0, init_done=0, prot_err=0; ack=0.
- INIT:
  - ack=0 regardless of req.
  - Each edge: wr_en<=1, wr_sel<=cnt, wr_data<=0, cnt<=cnt+1.
  - On the edge where cnt==15: state<=RUN and init_done<=1.
  - Total: exactly 16 writes, registers 0..15 in order.
- RUN arbitration:
  - Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first i with req[i]=1 wins: ack[i]=1, all other ack bits 0.
  - Each edge with a winner i: wr_en<=1, wr_sel<=req_addr_i, wr_data<=req_data_i, ptr<=(i+1) mod 4.
  - Each edge with no request: wr_en<=0; wr_sel and wr_data hold; ptr holds.
- Handshake:
  - A requester holds req, addr, and data stable until it sees ack=1.
  - req still high on the edge after an ack is a new, independent write.
  - Losing requesters are not acked and simply wait. Round-robin guarantees a wait of at most 3 grants.
- Same-register collisions across requesters are not merged. Each is a separate write in grant order, and the last write wins.
- ack depends only on req, ptr, and state. It has no dependence on req_addr or req_data.
- init_done stays 1 until the next reset.

## Timing
- ack is combinational in the same cycle as req (RUN only).
- Write latency is 1 cycle: the write captured at edge t appears on wr_* after edge t. The register file captures it at edge t+1.
- Throughput is 1 write per cycle sustained.
- Reset asserted mid-INIT or mid-RUN takes effect at the next edge:
  - Any in-flight wr_en is dropped (wr_en=0 after that edge).
  - The zero-fill restarts from register 0.
- First RUN grant is possible during the cycle after the 16th INIT edge. req asserted during INIT is served then, in rr order starting at requester 0.

## Configuration
- Macro RF_WR_PROT_EN.
- Defined: register 0 is hard-wired zero.
  - A RUN grant with req_addr_i==0 is still acked and still advances ptr.
  - For that grant, wr_en<=0 and prot_err<=1 for one cycle.
  - INIT still writes register 0.
- Undefined: register 0 is writable like any other. prot_err is not generated and is tied to 0.

## Test plan
- Reset then idle:
  - Observe 16 cycles of wr_en=1 with wr_sel=0,1,...,15 and wr_data=0.
  - init_done rises with the last of them; wr_en=0 afterwards.
  - ack stays 0 throughout, even with req=4'b1111 held.
- All four req held constantly in RUN, addresses 1,2,3,4:
  - ack sequence 0001,0010,0100,1000,0001.
  - wr_sel sequence 1,2,3,4,1, each one cycle after its ack.
- ptr=2 with req=4'b0011 → ack=0001, ptr becomes 1. Next cycle req=4'b0011 → ack=0010.
- Reset asserted at INIT cnt=7, and separately during a RUN write → wr_en=0 next cycle, then the fill restarts from wr_sel=0.
- With RF_WR_PROT_EN, requester 3 writes addr 0 data 8'hAA → ack[3]=1, wr_en=0, prot_err pulses 1 cycle. Without the macro → wr_en=1, wr_sel=0, wr_data=8'hAA.
